// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between pipeline writeback
//            and a long-latency unit, buffering results in a small FIFO.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_pipe_we,
   input  logic [AW-1:0] i_pipe_wra,
   input  logic [DW-1:0] i_pipe_wd,
   output logic          o_pipe_stall,
   input  logic          i_llu_valid,
   output logic          o_llu_ready,
   input  logic [AW-1:0] i_llu_wra,
   input  logic [DW-1:0] i_llu_wd,
   input  logic [AW-1:0] i_chk_ra,
   output logic          o_pend_hit,
   output logic          o_rf_we,
   output logic [AW-1:0] o_rf_wra,
   output logic [DW-1:0] o_rf_wd
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [SW-1:0] C_SMAX  = SW'(STARVE_MAX);

   logic [DW-1:0]    data_q [DEPTH];
   logic [AW-1:0]    tag_q  [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_wra_q, rf_wra_d;
   logic [DW-1:0]    rf_wd_q, rf_wd_d;

   logic w_empty, w_ready, w_stall, w_pipe_live, w_llu_live;
   logic w_push, w_pop, w_byp;

   assign w_empty     = (cnt_q == '0);
   assign w_ready     = (cnt_q < C_DEPTH);
   assign w_stall     = (starve_q == C_SMAX) && !w_empty;
   // Register-0 writes are swallowed here so they never reach the port or FIFO.
   assign w_pipe_live = i_pipe_we && (i_pipe_wra != '0);
   assign w_llu_live  = i_llu_valid && w_ready && (i_llu_wra != '0);

   assign o_llu_ready  = w_ready;
   assign o_pipe_stall = w_stall;
   assign o_rf_we      = rf_we_q;
   assign o_rf_wra     = rf_wra_q;
   assign o_rf_wd      = rf_wd_q;

   always_comb begin
      w_pop    = 1'b0;
      w_byp    = 1'b0;
      starve_d = starve_q;
      rf_we_d  = 1'b0;
      rf_wra_d = rf_wra_q;
      rf_wd_d  = rf_wd_q;
      if (w_stall) begin
         w_pop    = 1'b1;
         starve_d = '0;
         rf_we_d  = 1'b1;
         rf_wra_d = tag_q[rptr_q];
         rf_wd_d  = data_q[rptr_q];
      end else if (w_pipe_live) begin
         rf_we_d  = 1'b1;
         rf_wra_d = i_pipe_wra;
         rf_wd_d  = i_pipe_wd;
         if (w_empty)
            starve_d = '0;
         else if (starve_q != C_SMAX)
            starve_d = starve_q + 1'b1;
      end else if (!w_empty) begin
         w_pop    = 1'b1;
         starve_d = '0;
         rf_we_d  = 1'b1;
         rf_wra_d = tag_q[rptr_q];
         rf_wd_d  = data_q[rptr_q];
      end else begin
         starve_d = '0;
         if (w_llu_live) begin
            w_byp    = 1'b1;
            rf_we_d  = 1'b1;
            rf_wra_d = i_llu_wra;
            rf_wd_d  = i_llu_wd;
         end
      end
      w_push = w_llu_live && !w_byp;
   end

   always_comb begin
      vld_d  = vld_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (w_pop) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = rptr_q + 1'b1;
      end
      if (w_push) begin
         vld_d[wptr_q] = 1'b1;
         wptr_d        = wptr_q + 1'b1;
      end
      if (w_push && !w_pop)
         cnt_d = cnt_q + 1'b1;
      else if (w_pop && !w_push)
         cnt_d = cnt_q - 1'b1;
   end

   always_comb begin
      o_pend_hit = w_byp && (i_llu_wra == i_chk_ra);
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (tag_q[i] == i_chk_ra))
            o_pend_hit = 1'b1;
      end
      if (i_chk_ra == '0)
         o_pend_hit = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         rf_we_q  <= 1'b0;
         rf_wra_q <= '0;
         rf_wd_q  <= '0;
      end else begin
         vld_q    <= vld_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         rf_we_q  <= rf_we_d;
         rf_wra_q <= rf_wra_d;
         rf_wd_q  <= rf_wd_d;
      end
   end

   // Payload storage needs no reset; vld_q qualifies every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         data_q[wptr_q] <= i_llu_wd;
         tag_q[wptr_q]  <= i_llu_wra;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_pipe_we;
   logic [AW-1:0] i_pipe_wra;
   logic [DW-1:0] i_pipe_wd;
   logic          o_pipe_stall;
   logic          i_llu_valid;
   logic          o_llu_ready;
   logic [AW-1:0] i_llu_wra;
   logic [DW-1:0] i_llu_wd;
   logic [AW-1:0] i_chk_ra;
   logic          o_pend_hit;
   logic          o_rf_we;
   logic [AW-1:0] o_rf_wra;
   logic [DW-1:0] o_rf_wd;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(2), .STARVE_MAX(4)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_pipe_we   (i_pipe_we),
      .i_pipe_wra  (i_pipe_wra),
      .i_pipe_wd   (i_pipe_wd),
      .o_pipe_stall(o_pipe_stall),
      .i_llu_valid (i_llu_valid),
      .o_llu_ready (o_llu_ready),
      .i_llu_wra   (i_llu_wra),
      .i_llu_wd    (i_llu_wd),
      .i_chk_ra    (i_chk_ra),
      .o_pend_hit  (o_pend_hit),
      .o_rf_we     (o_rf_we),
      .o_rf_wra    (o_rf_wra),
      .o_rf_wd     (o_rf_wd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic we, input logic [AW-1:0] ra, input logic [DW-1:0] d);
      i_pipe_we  = we;
      i_pipe_wra = ra;
      i_pipe_wd  = d;
   endtask

   task automatic llu(input logic v, input logic [AW-1:0] ra, input logic [DW-1:0] d);
      i_llu_valid = v;
      i_llu_wra   = ra;
      i_llu_wd    = d;
   endtask

   initial begin
      rst = 1'b1;
      pipe(1'b0, '0, '0);
      llu(1'b0, '0, '0);
      i_chk_ra = 5'd5;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_we",    64'(o_rf_we),      64'd0);
      check_eq("rst_wra",   64'(o_rf_wra),     64'd0);
      check_eq("rst_wd",    64'(o_rf_wd),      64'd0);
      check_eq("rst_ready", 64'(o_llu_ready),  64'd1);
      check_eq("rst_stall", 64'(o_pipe_stall), 64'd0);
      check_eq("rst_hit",   64'(o_pend_hit),   64'd0);
      rst = 1'b0;
      step();

      // Bypass on an idle port
      llu(1'b1, 5'd7, 32'h11);
      i_chk_ra = 5'd7;
      #1;
      check_eq("byp_ready", 64'(o_llu_ready), 64'd1);
      check_eq("byp_hit",   64'(o_pend_hit),  64'd1);
      step();
      llu(1'b0, '0, '0);
      #1;
      check_eq("byp_we",  64'(o_rf_we),  64'd1);
      check_eq("byp_wra", 64'(o_rf_wra), 64'd7);
      check_eq("byp_wd",  64'(o_rf_wd),  64'h11);
      check_eq("byp_hit_after", 64'(o_pend_hit), 64'd0);
      step();
      check_eq("byp_idle_we", 64'(o_rf_we), 64'd0);

      // Starvation: pipe writes r3 continuously while r9 waits
      pipe(1'b1, 5'd3, 32'h33);
      llu(1'b1, 5'd9, 32'hAA);
      i_chk_ra = 5'd9;
      #1;
      check_eq("st_c0_stall", 64'(o_pipe_stall), 64'd0);
      step();
      llu(1'b0, '0, '0);
      #1;
      for (int k = 0; k < 4; k++) begin
         check_eq("st_stall_lo", 64'(o_pipe_stall), 64'd0);
         check_eq("st_pipe_wra", 64'(o_rf_wra),     64'd3);
         step();
      end
      check_eq("st_stall_hi", 64'(o_pipe_stall), 64'd1);
      check_eq("st_hit9",     64'(o_pend_hit),   64'd1);
      step();
      check_eq("st_drain_wra", 64'(o_rf_wra),     64'd9);
      check_eq("st_drain_wd",  64'(o_rf_wd),      64'hAA);
      check_eq("st_drain_we",  64'(o_rf_we),      64'd1);
      check_eq("st_unstall",   64'(o_pipe_stall), 64'd0);
      step();
      check_eq("st_resume_wra", 64'(o_rf_wra), 64'd3);
      check_eq("st_resume_wd",  64'(o_rf_wd),  64'h33);
      pipe(1'b0, '0, '0);
      step();

      // Fill the FIFO while pipe busy, then drain in order
      pipe(1'b1, 5'd3, 32'h33);
      llu(1'b1, 5'd4, 32'h44);
      step();
      llu(1'b1, 5'd5, 32'h55);
      step();
      llu(1'b1, 5'd6, 32'h66);
      pipe(1'b0, '0, '0);
      #1;
      check_eq("full_ready", 64'(o_llu_ready), 64'd0);
      step();
      check_eq("dr_wra4",   64'(o_rf_wra),    64'd4);
      check_eq("dr_wd4",    64'(o_rf_wd),     64'h44);
      check_eq("dr_ready",  64'(o_llu_ready), 64'd1);
      i_chk_ra = 5'd5;
      #1;
      check_eq("pend_hit5", 64'(o_pend_hit), 64'd1);
      i_chk_ra = 5'd0;
      #1;
      check_eq("pend_hit0", 64'(o_pend_hit), 64'd0);
      step();
      llu(1'b0, '0, '0);
      check_eq("dr_wra5", 64'(o_rf_wra), 64'd5);
      check_eq("dr_wd5",  64'(o_rf_wd),  64'h55);
      step();
      check_eq("dr_wra6", 64'(o_rf_wra), 64'd6);
      check_eq("dr_wd6",  64'(o_rf_wd),  64'h66);
      i_chk_ra = 5'd5;
      #1;
      check_eq("pend_hit5_gone", 64'(o_pend_hit), 64'd0);
      step();
      check_eq("dr_idle_we", 64'(o_rf_we), 64'd0);

      // Register-0 writes from both sides are dropped
      pipe(1'b1, 5'd0, 32'hDEAD);
      llu(1'b1, 5'd0, 32'hBEEF);
      i_chk_ra = 5'd0;
      step();
      check_eq("r0_we",    64'(o_rf_we),      64'd0);
      check_eq("r0_ready", 64'(o_llu_ready),  64'd1);
      check_eq("r0_stall", 64'(o_pipe_stall), 64'd0);
      step();
      check_eq("r0_we2",   64'(o_rf_we),     64'd0);
      check_eq("r0_ready2", 64'(o_llu_ready), 64'd1);
      pipe(1'b0, '0, '0);
      llu(1'b0, '0, '0);
      step();

      // Asynchronous reset mid-drain with two entries buffered
      pipe(1'b1, 5'd3, 32'h33);
      llu(1'b1, 5'd10, 32'hA0);
      step();
      llu(1'b1, 5'd11, 32'hB0);
      step();
      pipe(1'b0, '0, '0);
      llu(1'b0, '0, '0);
      step();
      check_eq("mr_wra10", 64'(o_rf_wra), 64'd10);
      rst = 1'b1;
      i_chk_ra = 5'd11;
      #1;
      check_eq("mr_we",    64'(o_rf_we),     64'd0);
      check_eq("mr_wra",   64'(o_rf_wra),    64'd0);
      check_eq("mr_wd",    64'(o_rf_wd),     64'd0);
      check_eq("mr_ready", 64'(o_llu_ready), 64'd1);
      check_eq("mr_hit",   64'(o_pend_hit),  64'd0);
      step();
      rst = 1'b0;
      step();
      check_eq("mr_post_we1", 64'(o_rf_we), 64'd0);
      step();
      check_eq("mr_post_we2", 64'(o_rf_we), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
